// File: rtl/adc_sampler_if.sv
// Command/response/sample bundle between the ADC sampler and the ADC core.
// master = sampler side, slave = ADC/consumer side.
interface adc_sampler_if;
    logic        command_valid;
    logic [4:0]  command_channel;
    logic        command_startofpacket;
    logic        command_endofpacket;
    logic        command_ready;
    logic        response_valid;
    logic [4:0]  response_channel;
    logic [11:0] response_data;
    logic        response_startofpacket;
    logic        response_endofpacket;
    logic        sample_valid;
    logic [4:0]  sample_channel;
    logic [11:0] sample_data;
    logic        error;

    modport master (
        output command_valid, command_channel,
        output command_startofpacket, command_endofpacket,
        input  command_ready,
        input  response_valid, response_channel, response_data,
        input  response_startofpacket, response_endofpacket,
        output sample_valid, sample_channel, sample_data, error
    );

    modport slave (
        input  command_valid, command_channel,
        input  command_startofpacket, command_endofpacket,
        output command_ready,
        output response_valid, response_channel, response_data,
        output response_startofpacket, response_endofpacket,
        input  sample_valid, sample_channel, sample_data, error
    );
endinterface

// File: rtl/adc_sampler.sv
// Round-robin ADC scanner: issues one conversion per slot, averages
// 2^AVG_LOG2 results per channel and strobes the mean out.
module adc_sampler #(
    parameter int NUM_CH   = 2,
    parameter int CH0      = 1,
    parameter int AVG_LOG2 = 4,
    parameter int TIMEOUT  = 1023
) (
    input  logic clock_clk,
    input  logic reset_sink_reset,
    input  logic enable,
    adc_sampler_if.master bus
);
    localparam int SW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int AW = 12 + AVG_LOG2;
    localparam int CW = AVG_LOG2 + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, CMD, WAIT} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [SW-1:0] slot;
    logic [AW-1:0] acc [NUM_CH];
    logic [CW-1:0] cnt [NUM_CH];
    logic [TW-1:0] tcnt;
    logic [4:0]    cur_ch;
    logic [AW-1:0] sum;
    logic          hs;
    logic          hit;
    logic          miss;
    logic          tmo;
    logic          last;

    assign cur_ch = 5'(CH0) + 5'(slot);
    assign hs     = bus.command_valid && bus.command_ready;
    assign hit    = (state == WAIT) && bus.response_valid
                 && (bus.response_channel == cur_ch);
    assign miss   = (state == WAIT) && bus.response_valid
                 && (bus.response_channel != cur_ch);
    assign tmo    = (state == WAIT) && !hit
                 && (tcnt == TW'(TIMEOUT - 1));
    assign sum    = acc[slot] + AW'(bus.response_data);
    assign last   = (cnt[slot] == CW'((2 ** AVG_LOG2) - 1));

    // State register
    always_ff @(posedge clock_clk or posedge reset_sink_reset) begin
        if (reset_sink_reset) state <= IDLE;
        else                  state <= state_nxt;
    end

    // Next-state: a timeout retries the same slot regardless of enable
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (enable) state_nxt = CMD;
            CMD:  if (hs) state_nxt = WAIT;
            WAIT: begin
                if (hit)      state_nxt = enable ? CMD : IDLE;
                else if (tmo) state_nxt = CMD;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Command outputs follow the state; channel tracks the current slot
    always_comb begin
        bus.command_valid         = (state == CMD);
        bus.command_startofpacket = (state == CMD);
        bus.command_endofpacket   = (state == CMD);
        bus.command_channel       = cur_ch;
    end

    // Slot, accumulators, timeout counter, sample output and error flag
    always_ff @(posedge clock_clk or posedge reset_sink_reset) begin
        if (reset_sink_reset) begin
            slot               <= '0;
            tcnt               <= '0;
            bus.sample_valid   <= 1'b0;
            bus.sample_channel <= '0;
            bus.sample_data    <= '0;
            bus.error          <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                acc[i] <= '0;
                cnt[i] <= '0;
            end
        end else begin
            bus.sample_valid <= 1'b0;
            if (hs || hit || tmo)  tcnt <= '0;
            else if (state == WAIT) tcnt <= tcnt + 1'b1;
            if (miss || tmo) bus.error <= 1'b1;
            if (hit) begin
                slot <= (slot == SW'(NUM_CH - 1)) ? '0 : slot + 1'b1;
                if (last) begin
                    acc[slot]          <= '0;
                    cnt[slot]          <= '0;
                    bus.sample_valid   <= 1'b1;
                    bus.sample_channel <= cur_ch;
                    bus.sample_data    <= 12'(sum >> AVG_LOG2);
                end else begin
                    acc[slot] <= sum;
                    cnt[slot] <= cnt[slot] + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_adc_sampler.sv
// Scoreboard bench for adc_sampler: the bench plays the ADC, a
// per-channel sum/count model predicts strobes, a monitor checks them.
module tb_adc_sampler;
    localparam int NUM_CH   = 2;
    localparam int CH0      = 1;
    localparam int AVG_LOG2 = 2;
    localparam int TIMEOUT  = 15;
    localparam int NAVG     = 1 << AVG_LOG2;

    typedef struct {
        logic [4:0]  ch;
        logic [11:0] data;
    } samp_t;

    logic clk    = 1'b0;
    logic rst    = 1'b0;
    logic enable = 1'b0;

    adc_sampler_if bus ();

    adc_sampler #(
        .NUM_CH  (NUM_CH),
        .CH0     (CH0),
        .AVG_LOG2(AVG_LOG2),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock_clk       (clk),
        .reset_sink_reset(rst),
        .enable          (enable),
        .bus             (bus)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    samp_t       exp_q[$];
    samp_t       mon_e;
    int          m_sum[NUM_CH];
    int          m_n[NUM_CH];
    int          m_slot = 0;
    bit          m_err  = 1'b0;
    logic [4:0]  last_ch   = '0;
    logic [11:0] last_data = '0;
    int          hs_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Reference model: plain per-channel running sum and count
    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_sum[i] = 0;
            m_n[i]   = 0;
        end
        m_slot    = 0;
        m_err     = 1'b0;
        last_ch   = '0;
        last_data = '0;
        exp_q.delete();
    endtask

    task automatic model_accept(input int data);
        samp_t s;
        m_sum[m_slot] += data;
        m_n[m_slot]++;
        if (m_n[m_slot] == NAVG) begin
            s.ch   = 5'(CH0 + m_slot);
            s.data = 12'(m_sum[m_slot] / NAVG);
            exp_q.push_back(s);
            m_sum[m_slot] = 0;
            m_n[m_slot]   = 0;
        end
        m_slot = (m_slot + 1) % NUM_CH;
    endtask

    // Monitor: pops on every strobe, checks hold values otherwise
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.sample_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("sample_channel", bus.sample_channel, mon_e.ch);
                    chk("sample_data", bus.sample_data, mon_e.data);
                    last_ch   = mon_e.ch;
                    last_data = mon_e.data;
                end
            end else begin
                chk("hold_channel", bus.sample_channel, last_ch);
                chk("hold_data", bus.sample_data, last_data);
            end
        end
    end

    always @(posedge clk) begin
        if (bus.command_valid === 1'b1 && bus.command_ready === 1'b1)
            hs_cnt <= hs_cnt + 1;
    end

    task automatic wait_cmd(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (bus.command_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) chk("cmd_wait_expired", 0, 1);
    endtask

    // One full conversion as seen from the ADC side
    task automatic do_conv(input logic [11:0] data, input int stall,
                           input int delay, input bit bad,
                           input bit drop_en, input bit cmd_drop);
        bit ok;
        logic [4:0] ch;
        wait_cmd(ok);
        if (!ok) return;
        ch = 5'(CH0 + m_slot);
        chk("cmd_channel", bus.command_channel, ch);
        if (cmd_drop) enable = 1'b0;
        for (int i = 0; i < stall; i++) begin
            bus.command_ready = 1'b0;
            @(negedge clk);
            chk("stall_valid", bus.command_valid, 1);
            chk("stall_channel", bus.command_channel, ch);
        end
        enable = 1'b1;
        bus.command_ready = 1'b1;
        @(negedge clk);
        bus.command_ready = 1'b0;
        chk("valid_after_hs", bus.command_valid, 0);
        if (drop_en) enable = 1'b0;
        repeat (delay) @(negedge clk);
        if (bad) begin
            bus.response_valid   = 1'b1;
            bus.response_channel = 5'd3;
            bus.response_data    = 12'd4095;
            @(negedge clk);
            bus.response_valid = 1'b0;
            m_err = 1'b1;
            chk("err_after_mismatch", bus.error, 1);
            chk("wait_after_mismatch", bus.command_valid, 0);
        end
        model_accept(int'(data));
        bus.response_valid   = 1'b1;
        bus.response_channel = ch;
        bus.response_data    = data;
        @(negedge clk);
        bus.response_valid = 1'b0;
        chk("error_flag", bus.error, m_err);
        chk("cmd_after_resp", bus.command_valid, enable);
    endtask

    task automatic do_timeout();
        bit ok;
        int n;
        logic [4:0] ch;
        wait_cmd(ok);
        if (!ok) return;
        ch = 5'(CH0 + m_slot);
        bus.command_ready = 1'b1;
        @(negedge clk);
        bus.command_ready = 1'b0;
        n = 0;
        while (bus.command_valid !== 1'b1 && n < 40) begin
            if (n == TIMEOUT - 1) chk("err_before_timeout", bus.error, m_err);
            @(negedge clk);
            n++;
        end
        m_err = 1'b1;
        chk("timeout_cycles", n, TIMEOUT);
        chk("err_after_timeout", bus.error, 1);
        chk("reissue_channel", bus.command_channel, ch);
    endtask

    task automatic rand_conv();
        do_conv(12'($urandom_range(4095, 0)), $urandom_range(3, 0),
                $urandom_range(8, 0), 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int hs0;
        bus.command_ready          = 1'b0;
        bus.response_valid         = 1'b0;
        bus.response_channel       = '0;
        bus.response_data          = '0;
        bus.response_startofpacket = 1'b0;
        bus.response_endofpacket   = 1'b0;
        model_reset();

        #2 rst = 1'b1;
        #1;
        chk("rst_cmd_valid", bus.command_valid, 0);
        chk("rst_cmd_channel", bus.command_channel, CH0);
        chk("rst_sample_valid", bus.sample_valid, 0);
        chk("rst_sample_channel", bus.sample_channel, 0);
        chk("rst_sample_data", bus.sample_data, 0);
        chk("rst_error", bus.error, 0);
        repeat (3) @(negedge clk);
        rst    = 1'b0;
        enable = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            do_conv(12'(100 + i), 0, 1, 1'b0, 1'b0, 1'b0);
            do_conv(12'd0, 0, 0, 1'b0, 1'b0, 1'b0);
        end

        hs0 = hs_cnt;
        do_conv(12'd7, 5, 2, 1'b0, 1'b0, 1'b0);
        chk("bp_handshakes", hs_cnt - hs0, 1);
        do_conv(12'd9, 0, 0, 1'b0, 1'b0, 1'b0);

        do_conv(12'd500, 3, 1, 1'b0, 1'b0, 1'b1);
        do_conv(12'd600, 0, 2, 1'b0, 1'b0, 1'b0);

        do_conv(12'd1234, 0, 3, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("idle_no_cmd", bus.command_valid, 0);
        end
        enable = 1'b1;
        wait_cmd(ok);
        chk("reenable_channel", bus.command_channel, CH0 + 1);
        do_conv(12'd2345, 0, 1, 1'b0, 1'b0, 1'b0);

        do_timeout();
        do_conv(12'd321, 0, 0, 1'b0, 1'b0, 1'b0);
        do_conv(12'd123, 0, 0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 30; i++) rand_conv();

        do_conv(12'd4000, 0, 0, 1'b0, 1'b0, 1'b0);
        wait_cmd(ok);
        #2 rst = 1'b1;
        #1;
        chk("midrst_cmd_valid", bus.command_valid, 0);
        chk("midrst_error", bus.error, 0);
        chk("midrst_sample_data", bus.sample_data, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        wait_cmd(ok);
        chk("first_cmd_after_rst", bus.command_channel, CH0);

        do_conv(12'd200, 0, 2, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) rand_conv();

        enable = 1'b0;
        repeat (20) @(negedge clk);
        chk("pending_samples", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/adc_sampler.md
ADC_SAMPLER -- requirements
Module: adc_sampler

Interface
REQ-001 Parameter NUM_CH, default 2, number of ADC channels scanned round-robin (1..8).
REQ-002 Parameter CH0, default 1, ADC channel number of scan slot 0; slot k uses channel CH0+k.
REQ-003 Parameter AVG_LOG2, default 4, log2 of the number of conversions averaged per output sample (0..8).
REQ-004 Parameter TIMEOUT, default 1023, the number of WAIT cycles without a matching response before a retry.
REQ-005 clock_clk  in  1  The single clock for all logic.
REQ-006 reset_sink_reset  in  1  Asynchronous, active-high reset.
REQ-007 enable  in  1  Scanning is allowed while high.
REQ-008 command_valid  out  1  A conversion request is present.
REQ-009 command_channel  out  5  The channel to convert.
REQ-010 command_startofpacket  out  1  Equals command_valid.
REQ-011 command_endofpacket  out  1  Equals command_valid.
REQ-012 command_ready  in  1  The ADC accepts the command.
REQ-013 response_valid  in  1  A conversion result is present.
REQ-014 response_channel  in  5  The channel of the result.
REQ-015 response_data  in  12  The conversion result, unsigned.
REQ-016 response_startofpacket, response_endofpacket  in  1 each  Ignored.
REQ-017 sample_valid  out  1  One-cycle strobe for an averaged sample.
REQ-018 sample_channel  out  5  The channel of the averaged sample.
REQ-019 sample_data  out  12  The averaged sample, unsigned.
REQ-020 error  out  1  Sticky flag for a channel mismatch or a timeout.

Function
REQ-021 The FSM SHALL have three states: IDLE, CMD and WAIT. Reset enters IDLE.
REQ-022 IDLE SHALL move to CMD in the cycle after enable is sampled high.
REQ-023 In CMD, command_valid SHALL be 1 and command_channel SHALL be CH0+slot; both SHALL stay stable until command_valid&&command_ready.
REQ-024 A command handshake SHALL move the FSM to WAIT and clear the timeout counter. command_valid SHALL be 0 in the next cycle.
REQ-025 Deasserting enable in CMD SHALL NOT withdraw command_valid; the transaction completes normally.
REQ-026 In WAIT, response_valid with response_channel==CH0+slot SHALL:
- add response_data to acc[slot] (width 12+AVG_LOG2, no overflow possible);
- increment cnt[slot];
- advance slot, wrapping from NUM_CH-1 to 0;
- go to CMD if enable=1, else to IDLE.
REQ-027 In WAIT, response_valid with any other channel SHALL discard the data, set error, and keep the FSM in WAIT.
REQ-028 Response handling: response_valid outside WAIT SHALL be ignored and SHALL NOT set error.
REQ-029 Timeout: after TIMEOUT consecutive WAIT cycles with no matching response, the block SHALL set error and return to CMD with the same slot, whatever the state of enable.
REQ-030 When cnt[slot] reaches 2^AVG_LOG2, in the cycle after the accepting response:
- sample_valid=1 for one cycle;
- sample_channel=CH0+slot;
- sample_data=(acc+new data)>>AVG_LOG2, truncated;
- acc[slot] and cnt[slot] SHALL clear to 0.
REQ-031 sample_channel and sample_data SHALL hold their last values between strobes.
REQ-032 Accumulators and counters SHALL keep their values across enable low periods; only reset clears them.
REQ-033 error SHALL clear only on reset.
REQ-034 Minimum conversion cycle: the next command SHALL be presented no later than 1 cycle after an accepted response.

Reset
REQ-035 Reset SHALL asynchronously force the following, aborting any in-flight command or wait:
- IDLE, slot=0;
- all acc/cnt=0;
- command_valid=0, command_channel=CH0;
- sample_valid=0, sample_channel=0, sample_data=0;
- error=0;
- timeout counter=0.
REQ-036 After reset release, the first command SHALL be issued for CH0.

Verification (NUM_CH=2, CH0=1, AVG_LOG2=2, TIMEOUT=15)
REQ-037 Basic average: enable=1, ready=1, the ch1 responses are 100,101,102,103 and the ch2 responses are 0 -> one strobe with sample_channel=1 and sample_data=101, commands alternating 1,2,1,2, and error=0.
REQ-038 Backpressure: command_ready=0 for 5 cycles -> command_valid and command_channel stay constant all 5 cycles, and there is exactly one handshake.
REQ-039 Mismatch: in WAIT for ch1, a response with channel 3 and data 4095 -> error=1, the data is not accumulated, and the later ch1 response completes normally.
REQ-040 Timeout: no response for 15 WAIT cycles -> error=1, and ch1 is reissued in the next cycle.
REQ-041 Enable low: enable drops during WAIT -> the response is accepted, the FSM goes to IDLE, and no command is issued. Re-enable -> the next command is for ch2.
REQ-042 Reset mid-operation: reset is asserted during CMD -> command_valid=0 immediately, then the first command after release is for ch1, with a 4-response average starting fresh.
